apb_master_bridge: RTL and testbench

- APB initiator: converts single-outstanding CPU load/store requests into APB3/APB4 SETUP/ACCESS transfers.
- Drives the shared APB bus that peripheral slaves (UART, GPIO, timer) respond on.
- Returns read data and an error flag to the CPU load/store unit.
- Includes a PREADY-stall timeout so a hung slave cannot lock up the core.

---
 rtl/apb_master_bridge.sv | 157 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB3/APB4 initiator: turns single-outstanding CPU load/store requests into SETUP/ACCESS
// transfers, with a PREADY-stall timeout and misaligned-address rejection.
module apb_master_bridge #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned STRB_W  = DATA_W / 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_strb,

    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,

    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    output logic [STRB_W-1:0] PSTRB,
    output logic              PSEL,
    output logic              PENABLE,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } state_e;

    state_e              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_paddr;
    logic                r_pwrite;
    logic [DATA_W-1:0]   r_pwdata;
    logic [STRB_W-1:0]   r_pstrb;
    logic                r_psel;
    logic                r_penable;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;

    logic                w_accept;
    logic                w_aligned;
    logic                w_timeout;

    assign req_ready = (r_state == StIdle) && !rst;
    assign w_accept  = req_valid && req_ready;
    assign w_aligned = (req_addr[1:0] == 2'b00);

    // Counter value during the k-th stalled ACCESS cycle is k-1, so the abort
    // lands on ACCESS cycle number TIMEOUT.
    if (TIMEOUT != 0) begin : g_timeout
        assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
    end else begin : g_no_timeout
        assign w_timeout = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        if (w_aligned) begin
                            r_state   <= StSetup;
                            r_psel    <= 1'b1;
                            r_penable <= 1'b0;
                            r_paddr   <= req_addr;
                            r_pwrite  <= req_write;
                            r_pwdata  <= req_write ? req_wdata : '0;
                            r_pstrb   <= req_write ? req_strb : '0;
                        end else begin
                            // Misaligned: answer with an error, no bus cycle.
                            r_state     <= StResp;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end
                    end
                end

                StSetup: begin
                    r_state   <= StAccess;
                    r_penable <= 1'b1;
                end

                StAccess: begin
                    if (PREADY) begin
                        r_state     <= StResp;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_cnt       <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= PSLVERR;
                        r_rsp_rdata <= (!r_pwrite && !PSLVERR) ? PRDATA : '0;
                    end else if (w_timeout) begin
                        r_state     <= StResp;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_cnt       <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                StResp: begin
                    r_state     <= StIdle;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= '0;
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign PADDR     = r_paddr;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;
    assign PSTRB     = r_pstrb;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: a configurable APB slave model plus a response
// scoreboard fed when each request is driven.
module tb_apb_master_bridge;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    apb_master_bridge #(
        .ADDR_W (32),
        .DATA_W (32),
        .STRB_W (4),
        .TIMEOUT(16)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_write(req_write),
        .req_wdata(req_wdata),
        .req_strb (req_strb),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PSTRB    (PSTRB),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Slave model: ready after slv_wait wait states unless hung.
    int          slv_wait  = 0;
    bit          slv_hang  = 1'b0;
    bit          slv_err   = 1'b0;
    logic [31:0] slv_rdata = 32'h0;
    int          acc_cnt   = 0;

    always @(negedge clk) begin
        if (PSEL && PENABLE) acc_cnt = acc_cnt + 1;
        else                 acc_cnt = 0;
        PREADY  = PSEL && PENABLE && !slv_hang && (acc_cnt == slv_wait + 1);
        PSLVERR = PREADY && slv_err;
        PRDATA  = slv_rdata;
    end

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", {31'h0, rsp_valid}, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_rdata", rsp_rdata, e.rdata);
                chk("sb_err", {31'h0, rsp_err}, {31'h0, e.err});
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] er, input logic ee);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_addr  = a;
        req_write = w;
        req_wdata = d;
        req_strb  = s;
        exp_q.push_back('{rdata: er, err: ee});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Called at T+1; returns at the rsp_valid cycle with the count of ACCESS cycles seen.
    task automatic wait_rsp(output int acc);
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) break;
            if (PSEL && PENABLE) acc++;
        end
        chk("rsp_seen", {31'h0, rsp_valid}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int acc;

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_write = 1'b0;
        req_wdata = '0;
        req_strb  = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_psel", {31'h0, PSEL}, 32'h0);
        chk("rst_penable", {31'h0, PENABLE}, 32'h0);
        chk("rst_pwrite", {31'h0, PWRITE}, 32'h0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_pstrb", {28'h0, PSTRB}, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("rst_ready_low", {31'h0, req_ready}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'h0, req_ready}, 32'h1);

        // Zero-wait read
        slv_rdata = 32'hDEADBEEF;
        issue(32'h4000_0004, 1'b0, 32'h1234_5678, 4'hF, 32'hDEADBEEF, 1'b0);
        chk("rd_t1_psel", {31'h0, PSEL}, 32'h1);
        chk("rd_t1_penable", {31'h0, PENABLE}, 32'h0);
        chk("rd_t1_paddr", PADDR, 32'h4000_0004);
        chk("rd_t1_pwrite", {31'h0, PWRITE}, 32'h0);
        chk("rd_t1_pwdata", PWDATA, 32'h0);
        chk("rd_t1_pstrb", {28'h0, PSTRB}, 32'h0);
        chk("rd_t1_ready", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        chk("rd_t2_penable", {31'h0, PENABLE}, 32'h1);
        chk("rd_t2_pstrb", {28'h0, PSTRB}, 32'h0);
        @(negedge clk);
        chk("rd_t3_valid", {31'h0, rsp_valid}, 32'h1);
        chk("rd_t3_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("rd_t3_psel", {31'h0, PSEL}, 32'h0);
        @(negedge clk);
        chk("rd_t4_ready", {31'h0, req_ready}, 32'h1);
        chk("rd_t4_valid", {31'h0, rsp_valid}, 32'h0);

        // Write with 3 wait states
        slv_wait  = 3;
        slv_rdata = 32'hA5A5_A5A5;
        issue(32'h4000_0008, 1'b1, 32'h0000_0041, 4'h1, 32'h0, 1'b0);
        chk("wr_t1_pwrite", {31'h0, PWRITE}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wr_acc_penable", {31'h0, PENABLE}, 32'h1);
            chk("wr_acc_paddr", PADDR, 32'h4000_0008);
            chk("wr_acc_pwdata", PWDATA, 32'h0000_0041);
            chk("wr_acc_pstrb", {28'h0, PSTRB}, 32'h1);
        end
        @(negedge clk);
        chk("wr_t6_valid", {31'h0, rsp_valid}, 32'h1);
        chk("wr_t6_rdata", rsp_rdata, 32'h0);
        @(negedge clk);

        // Slave error on read
        slv_wait  = 0;
        slv_err   = 1'b1;
        slv_rdata = 32'hCAFE_F00D;
        issue(32'h4000_000C, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        wait_rsp(acc);
        chk("slverr_err", {31'h0, rsp_err}, 32'h1);
        chk("slverr_rdata", rsp_rdata, 32'h0);
        slv_err = 1'b0;
        @(negedge clk);

        // Timeout with PREADY held low
        slv_hang = 1'b1;
        issue(32'h4000_0010, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        wait_rsp(acc);
        chk("to_acc_cycles", acc, 32'd16);
        chk("to_err", {31'h0, rsp_err}, 32'h1);
        chk("to_psel_low", {31'h0, PSEL}, 32'h0);
        chk("to_ready_low", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        chk("to_ready_next", {31'h0, req_ready}, 32'h1);
        slv_hang = 1'b0;

        // PREADY on the 16th ACCESS cycle wins over the timeout
        slv_wait  = 15;
        slv_rdata = 32'h0BAD_F00D;
        issue(32'h4000_0014, 1'b0, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0);
        wait_rsp(acc);
        chk("late_acc_cycles", acc, 32'd16);
        chk("late_err", {31'h0, rsp_err}, 32'h0);
        @(negedge clk);

        // Misaligned request
        slv_wait = 0;
        issue(32'h4000_0002, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
        chk("mis_t1_valid", {31'h0, rsp_valid}, 32'h1);
        chk("mis_t1_err", {31'h0, rsp_err}, 32'h1);
        chk("mis_t1_psel", {31'h0, PSEL}, 32'h0);
        @(negedge clk);
        chk("mis_t2_psel", {31'h0, PSEL}, 32'h0);
        chk("mis_t2_ready", {31'h0, req_ready}, 32'h1);

        // Reset during ACCESS: no response for the aborted transfer
        slv_wait = 5;
        issue(32'h4000_0018, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        void'(exp_q.pop_back());
        @(negedge clk);
        @(negedge clk);
        chk("mrst_in_access", {31'h0, PENABLE}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_psel", {31'h0, PSEL}, 32'h0);
        chk("mrst_penable", {31'h0, PENABLE}, 32'h0);
        chk("mrst_paddr", PADDR, 32'h0);
        chk("mrst_valid", {31'h0, rsp_valid}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mrst_quiet", {31'h0, rsp_valid}, 32'h0);
        end
        slv_wait  = 0;
        slv_rdata = 32'h1122_3344;
        issue(32'h4000_001C, 1'b0, 32'h0, 4'h0, 32'h1122_3344, 1'b0);
        wait_rsp(acc);
        chk("post_rst_rdata", rsp_rdata, 32'h1122_3344);
        @(negedge clk);

        // Back-to-back with req_valid held
        slv_rdata = 32'h55AA_55AA;
        chk("b2b_ready0", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_addr  = 32'h4000_0020;
        req_write = 1'b0;
        exp_q.push_back('{rdata: 32'h55AA_55AA, err: 1'b0});
        @(negedge clk);
        req_addr = 32'h4000_0024;
        exp_q.push_back('{rdata: 32'h6677_8899, err: 1'b0});
        chk("b2b_t1_ready", {31'h0, req_ready}, 32'h0);
        chk("b2b_t1_paddr", PADDR, 32'h4000_0020);
        @(negedge clk);
        chk("b2b_t2_ready", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        chk("b2b_t3_ready", {31'h0, req_ready}, 32'h0);
        chk("b2b_t3_valid", {31'h0, rsp_valid}, 32'h1);
        slv_rdata = 32'h6677_8899;
        @(negedge clk);
        chk("b2b_t4_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_t5_psel", {31'h0, PSEL}, 32'h1);
        chk("b2b_t5_penable", {31'h0, PENABLE}, 32'h0);
        chk("b2b_t5_paddr", PADDR, 32'h4000_0024);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_t7_valid", {31'h0, rsp_valid}, 32'h1);

        repeat (3) @(negedge clk);
        chk("sb_drained", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
